count_rate_controller: RTL



---
 rtl/count_rate_controller_if.sv | 28 ++
 rtl/count_rate_controller.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/count_rate_controller_if.sv
// Board-side bundle for the count-rate controller: switches and buttons in,
// count-enable and status out.
interface count_rate_controller_if;
    logic [1:0] Sel;
    logic       RunBtn;
    logic       StepBtn;
    logic       CountEn;
    logic       Running;
    logic [1:0] SelQ;

    modport master (
        output Sel,
        output RunBtn,
        output StepBtn,
        input  CountEn,
        input  Running,
        input  SelQ
    );

    modport slave (
        input  Sel,
        input  RunBtn,
        input  StepBtn,
        output CountEn,
        output Running,
        output SelQ
    );
endinterface

// File: rtl/count_rate_controller.sv
// Single-clock count sequencer: turns rate switches and run/step buttons
// into a one-cycle enable pulse for the lab up-counter.
module count_rate_controller #(
    parameter int BASE_LOG2  = 20,
    parameter int DEB_CYCLES = 16
) (
    input  logic                   Clk,
    input  logic                   Rst,
    count_rate_controller_if.slave bus
);
    localparam int PW = BASE_LOG2 + 7;
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES);
    localparam logic [PW-1:0] ONES = '1;

    typedef enum logic {
        PAUSED = 1'b0,
        RUN    = 1'b1
    } state_e;

    logic [1:0] raw;
    logic [1:0] press;

    assign raw = {bus.StepBtn, bus.RunBtn};

    for (genvar b = 0; b < 2; b++) begin : g_btn
        logic          meta_q;
        logic          sync_q;
        logic          lvl_q;
        logic          lvl_d;
        logic          lvl_dly_q;
        logic          press_q;
        logic          press_d;
        logic [DW-1:0] cnt_q;
        logic [DW-1:0] cnt_d;

        // Level only moves after DEB_CYCLES consecutive disagreeing samples.
        always_comb begin
            lvl_d   = lvl_q;
            cnt_d   = '0;
            press_d = lvl_q & ~lvl_dly_q;
            if (cnt_q == DEB_MAX) begin
                lvl_d = sync_q;
            end else if (sync_q != lvl_q) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        always_ff @(posedge Clk or posedge Rst) begin
            if (Rst) begin
                meta_q    <= 1'b0;
                sync_q    <= 1'b0;
                lvl_q     <= 1'b0;
                lvl_dly_q <= 1'b0;
                press_q   <= 1'b0;
                cnt_q     <= '0;
            end else begin
                meta_q    <= raw[b];
                sync_q    <= meta_q;
                lvl_q     <= lvl_d;
                lvl_dly_q <= lvl_q;
                press_q   <= press_d;
                cnt_q     <= cnt_d;
            end
        end

        assign press[b] = press_q;
    end

    state_e        state_q;
    state_e        state_d;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic [PW-1:0] term;
    logic [1:0]    sel_q;
    logic          ce_q;
    logic          ce_d;
    logic          run_q;
    logic          run_press;
    logic          step_press;
    logic          sel_change;

    assign run_press  = press[0];
    assign step_press = press[1];
    assign sel_change = (bus.Sel != sel_q);

    // Terminal count is 2^(BASE_LOG2+2*sel)-1, i.e. ONES with 7-2*sel bits dropped.
    assign term = ONES >> (3'd7 - {sel_q, 1'b0});

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        ce_d    = 1'b0;
        unique case (state_q)
            PAUSED: begin
                presc_d = '0;
                if (run_press) begin
                    state_d = RUN;
                end else if (step_press) begin
                    ce_d = 1'b1;
                end
            end
            RUN: begin
                if (run_press) begin
                    state_d = PAUSED;
                    presc_d = '0;
                end else if (sel_change) begin
                    presc_d = '0;
                end else if (presc_q == term) begin
                    presc_d = '0;
                    ce_d    = 1'b1;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= PAUSED;
            presc_q <= '0;
            sel_q   <= 2'b00;
            ce_q    <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            sel_q   <= bus.Sel;
            ce_q    <= ce_d;
            run_q   <= (state_d == RUN);
        end
    end

    assign bus.CountEn = ce_q;
    assign bus.Running = run_q;
    assign bus.SelQ    = sel_q;

`ifndef SYNTHESIS
    a_no_back_to_back : assert property (
        @(posedge Clk) disable iff (Rst) bus.CountEn |=> !bus.CountEn
    );
`endif
endmodule
